// File: rtl/cache_sa.sv
// Set-associative write-back, write-allocate cache with round-robin replacement.
// One request is serviced at a time; misses walk COMPARE -> [WRITEBACK] -> ALLOCATE.
module cache_sa #(
  parameter int ADDR_W      = 30,
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                                clk,
  input  logic                                proc_reset_n,
  input  logic                                proc_read,
  input  logic                                proc_write,
  input  logic [ADDR_W-1:0]                   proc_addr,
  input  logic [31:0]                         proc_wdata,
  output logic [31:0]                         proc_rdata,
  output logic                                proc_stall,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0] mem_addr,
  output logic [32*BLOCK_WORDS-1:0]           mem_wdata,
  input  logic [32*BLOCK_WORDS-1:0]           mem_rdata,
  input  logic                                mem_ready
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = 32 * BLOCK_WORDS;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-1:0] dirty_q;
  logic [WAY_W-1:0]          rr_q [SETS];
  logic [WAY_W-1:0]          victim_q;
  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]         data_q [SETS][WAYS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             enable;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [LINE_W-1:0] hit_line;
  logic [WAY_W-1:0] victim_sel;
  logic             victim_found;
  logic             write_hit;
  logic             fill;
  logic             miss_latch;

  assign req_tag = proc_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = proc_addr[OFF_W +: IDX_W];
  assign req_off = proc_addr[OFF_W-1:0];
  assign enable  = proc_read ^ proc_write;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line   = data_q[req_idx][hit_way];
  assign proc_rdata = hit ? hit_line[{req_off, 5'b0} +: 32] : 32'h0;
  assign proc_stall = enable & ~hit;

  // Prefer an empty way; only evict by round-robin when the set is full.
  always_comb begin
    victim_sel   = rr_q[req_idx];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[req_idx][w]) begin
        victim_sel   = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  assign write_hit  = (state_q == COMPARE) && proc_write && !proc_read && hit;
  assign fill       = (state_q == ALLOCATE) && mem_ready;
  assign miss_latch = (state_q == COMPARE) && enable && !hit;

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      COMPARE: begin
        if (enable && !hit) begin
          if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel])
            state_d = WRITEBACK;
          else
            state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {tag_q[req_idx][victim_q], req_idx};
        mem_wdata = data_q[req_idx][victim_q];
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = proc_addr[ADDR_W-1:OFF_W];
        if (mem_ready) state_d = COMPARE;
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q  <= COMPARE;
      valid_q  <= '0;
      dirty_q  <= '0;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (miss_latch) victim_q <= victim_sel;
      if (write_hit) dirty_q[req_idx][hit_way] <= 1'b1;
      if (fill) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
        rr_q[req_idx]              <= WAY_W'((int'(victim_q) + 1) % WAYS);
      end
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (write_hit) data_q[req_idx][hit_way][{req_off, 5'b0} +: 32] <= proc_wdata;
    if (fill) begin
      tag_q[req_idx][victim_q]  <= req_tag;
      data_q[req_idx][victim_q] <= mem_rdata;
    end
  end

endmodule

// File: doc/cache_sa.md
CACHE_SA -- requirements
Module: cache_sa

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 30, meaning processor word-address width.
REQ-002 The block SHALL have parameter SETS, default 8, meaning set count, power of 2, at least 2.
REQ-003 The block SHALL have parameter WAYS, default 2, meaning associativity, one of 1/2/4.
REQ-004 The block SHALL have parameter BLOCK_WORDS, default 4, meaning 32-bit words per line, power of 2, at least 2.
REQ-005 Derived widths SHALL be OFF_W=log2(BLOCK_WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, and proc_addr SHALL split as {tag,index,offset}.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port proc_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have ports proc_read and proc_write, input, 1 bit each: request strobes.
REQ-009 The block SHALL have port proc_addr, input, ADDR_W bits: word address.
REQ-010 The block SHALL have port proc_wdata, input, 32 bits: store data.
REQ-011 The block SHALL have port proc_rdata, output, 32 bits: load data.
REQ-012 The block SHALL have port proc_stall, output, 1 bit: processor must hold its request while high.
REQ-013 The block SHALL have ports mem_read and mem_write, output, 1 bit each: memory requests.
REQ-014 The block SHALL have port mem_addr, output, ADDR_W-OFF_W bits: line address.
REQ-015 The block SHALL have port mem_wdata, output, 32*BLOCK_WORDS bits: write-back line.
REQ-016 The block SHALL have ports mem_rdata, input, 32*BLOCK_WORDS bits, and mem_ready, input, 1 bit: fill line and completion.

Function
REQ-017 The block SHALL be a WAYS-way set-associative, write-back, write-allocate cache; word k of a line occupies bits [32k+31:32k] on both mem buses.
REQ-018 enable = proc_read XOR proc_write; with both strobes equal, the block SHALL issue no stall, no memory access and no array update.
REQ-019 A hit SHALL be a valid way in the indexed set whose tag matches; at most one way hits.
REQ-020 proc_stall SHALL be combinational: enable AND NOT hit.
REQ-021 proc_rdata SHALL be the offset word of the hitting way, else 0.
REQ-022 On a write hit in COMPARE, the block SHALL update the offset word and set that way's dirty bit at the clock edge, with zero stall.
REQ-023 The FSM SHALL have states COMPARE, WRITEBACK and ALLOCATE.
REQ-024 In COMPARE, a miss SHALL latch the victim way into a register: the lowest-numbered invalid way if any exist, else the set's round-robin pointer.
REQ-025 From COMPARE, a miss SHALL go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
REQ-026 In WRITEBACK, the block SHALL drive mem_write=1, mem_addr={victim tag, index} and mem_wdata=victim line, hold them until mem_ready, then go to ALLOCATE.
REQ-027 In ALLOCATE, the block SHALL drive mem_read=1 and mem_addr=proc_addr[ADDR_W-1:OFF_W]; on mem_ready it SHALL write the line, tag, valid=1 and dirty=0 into the victim way, set the set pointer to (victim+1) mod WAYS, and go to COMPARE.
REQ-028 After a fill, the request SHALL hit in the next COMPARE cycle, and a pending write SHALL be applied then.
REQ-029 Once WRITEBACK or ALLOCATE is entered, the sequence SHALL complete even if enable drops; memory handshakes SHALL never be abandoned.
REQ-030 mem_read and mem_write SHALL never be high together, and both SHALL be 0 in COMPARE.
REQ-031 With WAYS=1, behaviour SHALL reduce to a direct-mapped write-back cache.

Reset
REQ-032 While proc_reset_n=0, the block SHALL immediately force state=COMPARE and clear all valid bits, dirty bits, round-robin pointers and the victim register.
REQ-033 In reset, mem_read and mem_write SHALL be 0 and proc_rdata SHALL be 0; tag and data arrays need not be cleared.
REQ-034 Reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL drop the memory request in the same cycle and discard the transaction.

Verification (defaults: SETS=8, WAYS=2, BLOCK_WORDS=4)
REQ-035 Cold read miss: read 0x10 -> stall=1, mem_read=1, mem_addr=0x4; mem_ready with word0=0xAAAA0000 -> next cycle stall=0, rdata=0xAAAA0000.
REQ-036 Two ways: fill 0x10 then 0x30 (both set 4) -> re-reading 0x10 and 0x30 hits with no memory access.
REQ-037 Dirty eviction: write 0x12=0x12345678 (hit), then read 0x50 -> WRITEBACK of way 0 with mem_addr=0x4 and word2=0x12345678, then ALLOCATE with mem_addr=0x14.
REQ-038 proc_read=proc_write=1 on a miss address -> stall=0, mem_read=mem_write=0, no state change.
REQ-039 mem_ready delayed 5 cycles in both WRITEBACK and ALLOCATE -> mem outputs stable each cycle, and proc_stall stays high until the cycle after the fill.
REQ-040 proc_reset_n low mid-ALLOCATE -> mem_read=0 immediately; after release, a read of the same address misses.
